univ_shift_reg: RTL and testbench

Parametrised universal register, the next generation of the team's single-bit D storage element. It provides a WIDTH-bit register with complementary outputs and eight single-cycle operations: hold, load, shift and rotate in both directions, clear, and set. It adds a multi-cycle shift/rotate engine driven by a small FSM, with busy/done status. It is used as a general data-path register and serialiser/deserialiser.

---
 rtl/univ_shift_reg.sv | 108 ++++++++++
 tb/tb_univ_shift_reg.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/univ_shift_reg.sv
// Universal WIDTH-bit register: eight single-cycle ops (hold/load/shift/rotate/clear/set)
// plus a counted multi-cycle shift/rotate engine with busy/done status.
module univ_shift_reg #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic             sout_l,
  output logic             sout_r,
  output logic             busy,
  output logic             done,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       op_mode, op_mode_nxt;
  logic             start_ok;

  function automatic logic [WIDTH-1:0] apply_op(
    input logic [2:0]       m,
    input logic [WIDTH-1:0] cur,
    input logic [WIDTH-1:0] din,
    input logic             sl,
    input logic             sr
  );
    logic [WIDTH-1:0] r;
    case (m)
      3'b001:  r = din;
      3'b010:  r = {cur[WIDTH-2:0], sr};
      3'b011:  r = {sl, cur[WIDTH-1:1]};
      3'b100:  r = {cur[WIDTH-2:0], cur[WIDTH-1]};
      3'b101:  r = {cur[0], cur[WIDTH-1:1]};
      3'b110:  r = '0;
      3'b111:  r = '1;
      default: r = cur;
    endcase
    return r;
  endfunction

  // Handshake: start is sampled only in IDLE/DONE and only for shift/rotate modes;
  // busy is high for every cycle the engine owns q, done pulses one cycle after the last step.
  assign start_ok = start && (mode >= 3'b010) && (mode <= 3'b101);

  always_comb begin
    state_nxt   = state;
    q_nxt       = q;
    cnt_nxt     = cnt;
    op_mode_nxt = op_mode;
    case (state)
      S_IDLE, S_DONE: begin
        state_nxt = S_IDLE;
        if (start_ok) begin
          op_mode_nxt = mode;
          cnt_nxt     = count;
          state_nxt   = (count != '0) ? S_RUN : S_DONE;
        end else if (en) begin
          q_nxt = apply_op(mode, q, d, sin_l, sin_r);
        end
      end
      S_RUN: begin
        q_nxt   = apply_op(op_mode, q, d, sin_l, sin_r);
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) state_nxt = S_DONE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      q       <= '0;
      cnt     <= '0;
      op_mode <= 3'b000;
    end else begin
      state   <= state_nxt;
      q       <= q_nxt;
      cnt     <= cnt_nxt;
      op_mode <= op_mode_nxt;
    end
  end

  assign q_bar     = ~q;
  assign sout_l    = q[WIDTH-1];
  assign sout_r    = q[0];
  assign busy      = (state == S_RUN);
  assign done      = (state == S_DONE);
  assign dbg_state = state;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg: per-feature tasks, expected q values
// queued when stimulus is driven and popped when the DUT result is sampled.
module tb_univ_shift_reg;
  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          en, start, sin_l, sin_r;
  logic [2:0]    mode;
  logic [W-1:0]  d;
  logic [CW-1:0] count;
  logic [W-1:0]  q, q_bar;
  logic          sout_l, sout_r, busy, done;
  logic [1:0]    dbg_state;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] e;
  logic [W-1:0] model_q;

  univ_shift_reg #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d), .sin_l(sin_l), .sin_r(sin_r),
    .start(start), .count(count), .q(q), .q_bar(q_bar), .sout_l(sout_l), .sout_r(sout_r),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  // driver tasks
  task automatic idle_inputs();
    en = 0; start = 0; mode = 3'b000; d = '0; sin_l = 0; sin_r = 0; count = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [W-1:0] v);
    idle_inputs();
    en = 1; mode = 3'b001; d = v;
    exp_q.push_back(v);
    tick();
    idle_inputs();
    e = exp_q.pop_front();
    checks++; if (q !== e) begin errors++; $display("FAIL load q=%h exp=%h", q, e); end
  endtask

  function automatic logic [W-1:0] model(input logic [2:0] m, input logic [W-1:0] cur,
                                         input logic [W-1:0] dd, input logic sl, input logic sr);
    case (m)
      3'b000:  return cur;
      3'b001:  return dd;
      3'b010:  return (cur << 1) | W'(sr);
      3'b011:  return (cur >> 1) | (W'(sl) << (W-1));
      3'b100:  return (cur << 1) | (cur >> (W-1));
      3'b101:  return (cur >> 1) | (cur << (W-1));
      3'b110:  return '0;
      default: return '1;
    endcase
  endfunction

  task automatic test_reset();
    rst = 0;
    idle_inputs();
    #3;
    checks++; if (q !== 8'h00)     begin errors++; $display("FAIL reset_q q=%h exp=00", q); end
    checks++; if (q_bar !== 8'hFF) begin errors++; $display("FAIL reset_qbar q_bar=%h exp=FF", q_bar); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_status busy=%b done=%b exp=0/0", busy, done); end
    tick(); tick();
    rst = 1;
    en = 1; mode = 3'b001; d = 8'hA5;
    exp_q.push_back(8'hA5);
    tick();
    idle_inputs();
    e = exp_q.pop_front();
    checks++; if (q !== e)      begin errors++; $display("FAIL first_load q=%h exp=%h", q, e); end
    checks++; if (q_bar !== ~e) begin errors++; $display("FAIL first_load_qbar q_bar=%h exp=%h", q_bar, ~e); end
  endtask

  task automatic test_single_ops();
    logic [2:0] modes[6] = '{3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111};
    logic [W-1:0] res[6] = '{8'h4B, 8'h52, 8'h4B, 8'hD2, 8'h00, 8'hFF};
    for (int i = 0; i < 6; i++) begin
      load(8'hA5);
      en = 1; mode = modes[i]; sin_r = 1; sin_l = 0;
      exp_q.push_back(res[i]);
      tick();
      idle_inputs();
      e = exp_q.pop_front();
      checks++; if (q !== e) begin errors++; $display("FAIL single_op mode=%b q=%h exp=%h", modes[i], q, e); end
      checks++; if (q_bar !== ~e || sout_l !== e[W-1] || sout_r !== e[0])
        begin errors++; $display("FAIL single_op_aux mode=%b q_bar=%h sl=%b sr=%b exp_q=%h", modes[i], q_bar, sout_l, sout_r, e); end
    end
    // en low: mode/d must not matter
    mode = 3'b001; d = 8'h3C;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(8'hFF);
      tick();
      e = exp_q.pop_front();
      checks++; if (q !== e) begin errors++; $display("FAIL hold edge=%0d q=%h exp=%h", i, q, e); end
    end
    idle_inputs();
  endtask

  task automatic test_random_ops();
    load(8'h5A);
    model_q = 8'h5A;
    for (int i = 0; i < 24; i++) begin
      en = 1'($urandom_range(0, 1)); mode = 3'($urandom_range(0, 7));
      d = W'($urandom_range(0, 255)); sin_l = 1'($urandom_range(0, 1)); sin_r = 1'($urandom_range(0, 1));
      if (en) model_q = model(mode, model_q, d, sin_l, sin_r);
      exp_q.push_back(model_q);
      tick();
      e = exp_q.pop_front();
      checks++; if (q !== e) begin errors++; $display("FAIL random_op i=%0d en=%b mode=%b q=%h exp=%h", i, en, mode, q, e); end
    end
    idle_inputs();
  endtask

  task automatic test_multi();
    load(8'h81);
    start = 1; mode = 3'b100; count = 4'd3;
    tick();  // E0
    idle_inputs();
    checks++; if (busy !== 1'b1 || done !== 1'b0 || q !== 8'h81)
      begin errors++; $display("FAIL multi_e0 busy=%b done=%b q=%h exp=1/0/81", busy, done, q); end
    exp_q.push_back(8'h03); exp_q.push_back(8'h06); exp_q.push_back(8'h0C);
    for (int s = 1; s <= 3; s++) begin
      tick();
      e = exp_q.pop_front();
      checks++; if (q !== e) begin errors++; $display("FAIL multi_step s=%0d q=%h exp=%h", s, q, e); end
      checks++; if (sout_l !== e[W-1] || sout_r !== e[0]) begin errors++; $display("FAIL multi_sout s=%0d sl=%b sr=%b exp=%b/%b", s, sout_l, sout_r, e[W-1], e[0]); end
      checks++; if (busy !== (s < 3) || done !== (s == 3))
        begin errors++; $display("FAIL multi_status s=%0d busy=%b done=%b", s, busy, done); end
    end
    tick();
    checks++; if (busy !== 1'b0 || done !== 1'b0 || q !== 8'h0C)
      begin errors++; $display("FAIL multi_after busy=%b done=%b q=%h exp=0/0/0C", busy, done, q); end
  endtask

  task automatic test_ignore_busy();
    load(8'h0C);
    start = 1; mode = 3'b100; count = 4'd3;
    tick();  // E0
    start = 1; count = 4'd5; en = 1; mode = 3'b001; d = 8'hFF;
    exp_q.push_back(8'h18); exp_q.push_back(8'h30); exp_q.push_back(8'h60);
    for (int s = 1; s <= 3; s++) begin
      tick();
      e = exp_q.pop_front();
      checks++; if (q !== e) begin errors++; $display("FAIL ignore_step s=%0d q=%h exp=%h", s, q, e); end
    end
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL ignore_done done=%b busy=%b exp=1/0", done, busy); end
    idle_inputs();
    tick();
    checks++; if (q !== 8'h60 || done !== 1'b0) begin errors++; $display("FAIL ignore_after q=%h done=%b exp=60/0", q, done); end
    // zero-count start
    start = 1; mode = 3'b010; count = '0; sin_r = 1;
    tick();
    idle_inputs();
    checks++; if (done !== 1'b1 || busy !== 1'b0 || q !== 8'h60)
      begin errors++; $display("FAIL zero_count done=%b busy=%b q=%h exp=1/0/60", done, busy, q); end
    tick();
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL zero_count_after done=%b busy=%b exp=0/0", done, busy); end
    // start with non-shift mode falls through to en
    start = 1; count = 4'd4; en = 1; mode = 3'b110;
    tick();
    idle_inputs();
    checks++; if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0)
      begin errors++; $display("FAIL bad_mode_start q=%h busy=%b done=%b exp=00/0/0", q, busy, done); end
  endtask

  task automatic test_back_to_back();
    load(8'h81);
    start = 1; mode = 3'b100; count = 4'd3;
    tick();
    idle_inputs();
    tick(); tick(); tick();  // E3: q=0C, DONE
    checks++; if (q !== 8'h0C || done !== 1'b1) begin errors++; $display("FAIL b2b_first q=%h done=%b exp=0C/1", q, done); end
    start = 1; mode = 3'b011; count = 4'd2; sin_l = 1;
    tick();
    start = 0; mode = 3'b000; count = '0;
    checks++; if (busy !== 1'b1 || done !== 1'b0 || q !== 8'h0C)
      begin errors++; $display("FAIL b2b_e0 busy=%b done=%b q=%h exp=1/0/0C", busy, done, q); end
    exp_q.push_back(8'h86); exp_q.push_back(8'hC3);
    for (int s = 1; s <= 2; s++) begin
      tick();
      e = exp_q.pop_front();
      checks++; if (q !== e) begin errors++; $display("FAIL b2b_step s=%0d q=%h exp=%h", s, q, e); end
      checks++; if (busy !== (s < 2) || done !== (s == 2))
        begin errors++; $display("FAIL b2b_status s=%0d busy=%b done=%b", s, busy, done); end
    end
    idle_inputs();
    tick();
    checks++; if (done !== 1'b0 || q !== 8'hC3) begin errors++; $display("FAIL b2b_after done=%b q=%h exp=0/C3", done, q); end
  endtask

  task automatic test_reset_midrun();
    load(8'h81);
    start = 1; mode = 3'b100; count = 4'd10;
    tick();
    idle_inputs();
    exp_q.push_back(8'h03); exp_q.push_back(8'h06); exp_q.push_back(8'h0C); exp_q.push_back(8'h18);
    for (int s = 1; s <= 4; s++) begin
      tick();
      e = exp_q.pop_front();
      checks++; if (q !== e || busy !== 1'b1) begin errors++; $display("FAIL midrun_step s=%0d q=%h busy=%b exp=%h/1", s, q, busy, e); end
    end
    #2 rst = 0;
    #1;
    checks++; if (q !== 8'h00 || q_bar !== 8'hFF || busy !== 1'b0 || done !== 1'b0)
      begin errors++; $display("FAIL midrun_async q=%h q_bar=%h busy=%b done=%b exp=00/FF/0/0", q, q_bar, busy, done); end
    tick();
    rst = 1;
    for (int s = 0; s < 4; s++) begin
      tick();
      checks++; if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || dbg_state !== 2'd0)
        begin errors++; $display("FAIL post_reset s=%0d q=%h busy=%b done=%b state=%0d exp=00/0/0/0", s, q, busy, done, dbg_state); end
    end
  endtask

  initial begin
    test_reset();
    test_single_ops();
    test_random_ops();
    test_multi();
    test_ignore_busy();
    test_back_to_back();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
